seq_gen: RTL and testbench

Serial bit-stream generator; the transmit-side counterpart of the team's serial sequence detector.
Loads a programmable pattern of 1..W bits and emits it MSB-first on a single-bit output, repeated a programmable number of times.
Uses a start/busy/done handshake, with a valid qualifier on every bit.
Drives the detector's serial data input in block-level and system benches, and serves as a reusable stimulus source.

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq_bitcnt.sv | 42 ++++
 rtl/seq_gen.sv | 162 ++++++++++++++++
 tb/tb_seq_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial pattern generator and its companion detector bench.
package seq_pkg;

  localparam int W_DEF  = 8;
  localparam int RW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A pattern length is usable when it selects at least one and at most w bits.
  function automatic logic len_ok(input int unsigned len_v, input int unsigned w_v);
    return (len_v >= 32'd1) && (len_v <= w_v);
  endfunction

endpackage

// File: rtl/seq_bitcnt.sv
// Loadable down-counter that stops at its terminal value; used for bit index and repetitions.
module seq_bitcnt #(
  parameter int           N      = 8,
  parameter logic [N-1:0] TC_VAL = {N{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         dec,
  output logic [N-1:0] cnt,
  output logic         tc
);

  logic [N-1:0] cnt_d;
  logic [N-1:0] cnt_q;

  // Next count: load wins, otherwise step down but never past the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && !tc) begin
      cnt_d = cnt_q - N'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {N{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TC_VAL);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends len bits of pattern MSB-first, reps times, with
// start/busy/done handshake and a valid qualifier on every bit.
module seq_gen
  import seq_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int RW = RW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [W-1:0]           pattern,
  input  logic [$clog2(W+1)-1:0] len,
  input  logic [RW-1:0]          reps,
  input  logic                   abort,
  output logic                   dout,
  output logic                   valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int LW = $clog2(W + 1);
  localparam int BW = $clog2(W);

  state_t        state_q, state_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic          dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          bit_load_s, bit_dec_s, bit_tc_s;
  logic [BW-1:0] bit_val_s, bit_cnt_s, bit_nxt_s;
  logic [BW-1:0] len_m1_s, lenq_m1_s;
  logic          rep_load_s, rep_dec_s, rep_tc_s, rep_last_s;
  logic [RW-1:0] rep_cnt_s;

  assign len_m1_s  = BW'(len - LW'(1));
  assign lenq_m1_s = BW'(len_q - LW'(1));
  assign bit_nxt_s = bit_cnt_s - BW'(1);
  // A zero repetition count is unreachable in normal operation; finish rather than wrap.
  assign rep_last_s = rep_tc_s || (rep_cnt_s == {RW{1'b0}});

  seq_bitcnt #(.N(BW), .TC_VAL({BW{1'b0}})) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (bit_load_s),
    .load_val (bit_val_s),
    .dec      (bit_dec_s),
    .cnt      (bit_cnt_s),
    .tc       (bit_tc_s)
  );

  seq_bitcnt #(.N(RW), .TC_VAL(RW'(1))) u_rep_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rep_load_s),
    .load_val (reps),
    .dec      (rep_dec_s),
    .cnt      (rep_cnt_s),
    .tc       (rep_tc_s)
  );

  // FSM next state, next outputs and counter controls.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    len_d      = len_q;
    dout_d     = 1'b0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    bit_load_s = 1'b0;
    bit_dec_s  = 1'b0;
    bit_val_s  = lenq_m1_s;
    rep_load_s = 1'b0;
    rep_dec_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok(32'(len), 32'(W)) && (reps != {RW{1'b0}})) begin
            state_d    = SHIFT;
            pat_d      = pattern;
            len_d      = len;
            bit_load_s = 1'b1;
            bit_val_s  = len_m1_s;
            rep_load_s = 1'b1;
            dout_d     = pattern[len_m1_s];
            valid_d    = 1'b1;
            busy_d     = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_tc_s) begin
          if (rep_last_s) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            rep_dec_s  = 1'b1;
            bit_load_s = 1'b1;
            bit_val_s  = lenq_m1_s;
            dout_d     = pat_q[lenq_m1_s];
            valid_d    = 1'b1;
            busy_d     = 1'b1;
          end
        end else begin
          bit_dec_s = 1'b1;
          dout_d    = pat_q[bit_nxt_s];
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= {W{1'b0}};
      len_q   <= {LW{1'b0}};
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed scenarios plus random traffic against a
// queue-based model of the expected serial stream.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] len = 4'd0;
  logic [7:0] reps = 8'd0;
  logic       dout, valid, busy, done, err;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int cyc, nv;

  // Model: queue of bits still to be sent; head is the bit on dout this cycle.
  bit q[$];
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  bit was_done = 1'b0;

  seq_gen #(.W(8), .RW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .abort   (abort),
    .dout    (dout),
    .valid   (valid),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model update on each sampling edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      m_err    = 1'b0;
      if (q.size() > 0) begin
        if (abort) begin
          q.delete();
        end else begin
          void'(q.pop_front());
          if (q.size() == 0) m_done = 1'b1;
        end
      end else if (was_done) begin
        m_done = 1'b0;
      end else if (start) begin
        if (len >= 4'd1 && len <= 4'd8 && reps != 8'd0) begin
          for (int r = 0; r < int'(reps); r++)
            for (int i = int'(len) - 1; i >= 0; i--)
              q.push_back(pattern[i]);
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      chk("valid", valid, (q.size() > 0));
      chk("dout", dout, (q.size() > 0) ? q[0] : 1'b0);
      chk("busy", busy, (q.size() > 0));
      chk("done", done, m_done);
      chk("err", err, m_err);
    end
  end

  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r);
    @(negedge clk);
    pattern = p;
    len     = l;
    reps    = r;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int c, output int v);
    c = 1;
    v = 0;
    while (!done && c < maxc) begin
      if (valid) v++;
      @(negedge clk);
      c++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_dout", dout, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk_en = 1'b1;

    send(8'b0000_0010, 4'd3, 8'd10);
    wait_done(100, cyc, nv);
    chk("basic_nvalid", nv, 30);
    chk("basic_done_cyc", cyc, 31);

    send(8'h01, 4'd1, 8'd4);
    wait_done(20, cyc, nv);
    chk("len1_nvalid", nv, 4);
    chk("len1_done_cyc", cyc, 5);

    send(8'hA5, 4'd8, 8'd1);
    wait_done(20, cyc, nv);
    chk("a5_nvalid", nv, 8);

    send(8'hFF, 4'd0, 8'd3);
    chk("ill_len0_err", err, 1'b1);
    send(8'hFF, 4'd9, 8'd3);
    chk("ill_len9_err", err, 1'b1);
    chk("ill_len9_busy", busy, 1'b0);
    send(8'hFF, 4'd4, 8'd0);
    chk("ill_reps0_err", err, 1'b1);
    @(negedge clk);
    chk("ill_err_pulse", err, 1'b0);

    // Start during SHIFT and in DONE must be ignored; the IDLE one after is taken.
    send(8'h02, 4'd3, 8'd2);
    repeat (2) @(negedge clk);
    start = 1'b1; pattern = 8'hFF; len = 4'd8; reps = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, cyc, nv);
    chk("ign_done_cyc", cyc, 4);
    start = 1'b1; pattern = 8'h02; len = 4'd2; reps = 8'd1;
    @(negedge clk);
    chk("ign_done_start", valid, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("idle_start_accept", valid, 1'b1);
    wait_done(10, cyc, nv);
    chk("idle_start_done_cyc", cyc, 3);

    // Abort on the fifth valid bit, then abort coinciding with the final bit.
    send(8'h05, 4'd3, 8'd4);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    send(8'h02, 4'd2, 8'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_last_done", done, 1'b0);
    chk("abort_last_valid", valid, 1'b0);

    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 29) == 0);
      pattern = 8'($urandom);
      len     = 4'($urandom_range(0, 9));
      reps    = 8'($urandom_range(0, 4));
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a transfer.
    send(8'hA5, 4'd8, 8'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_dout", dout, 1'b0);
    chk("amid_valid", valid, 1'b0);
    chk("amid_busy", busy, 1'b0);
    chk("amid_done", done, 1'b0);
    chk("amid_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("amid_no_done", done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
